// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction-fetch stage: PC register, next-PC selection, IR latch and
// a one-entry buffer for redirects that arrive while instruction memory is busy.
module lc3b_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resp_a,
  input  logic [15:0] rdata_a,
  input  logic [15:0] trap_mem,
  input  logic        br_en,
  input  logic        trap_en,
  input  logic        jmp_jsr_en,
  input  logic        b11,
  input  logic [15:0] pc_br_in,
  input  logic [15:0] sr1_data_in,
  input  logic [2:0]  pcmux_sel,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] pc_out,
  output logic [15:0] instruction,
  output logic [2:0]  dest,
  output logic [2:0]  src1,
  output logic [2:0]  src2,
  output logic        read_a,
  output logic [15:0] address_a
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_tgt_q, pend_tgt_d;

  logic [2:0]  eff_sel;
  logic [15:0] plus2;
  logic [15:0] next_pc;
  logic        redir;
  logic        pc_load;

  assign plus2 = pc_q + 16'd2;
  assign redir = br_en | trap_en | jmp_jsr_en;

  // Live redirects outrank a buffered target, which outranks the default select.
  always_comb begin
    eff_sel = pcmux_sel;
    if (br_en)           eff_sel = 3'd1;
    else if (trap_en)    eff_sel = 3'd4;
    else if (jmp_jsr_en) eff_sel = b11 ? 3'd1 : 3'd2;
    else if (pend_q)     eff_sel = 3'd5;
  end

  always_comb begin
    next_pc = 16'h0000;
    case (eff_sel)
      3'd0:    next_pc = plus2;
      3'd1:    next_pc = pc_br_in;
      3'd2:    next_pc = sr1_data_in;
      3'd3:    next_pc = rdata_a;
      3'd4:    next_pc = trap_mem;
      3'd5:    next_pc = pend_tgt_q;
      default: next_pc = 16'h0000;
    endcase
  end

  // stall only holds back the sequential advance; redirects always get through.
  assign pc_load = (redir & resp_a) | pend_q | (~stall & resp_a);

  always_comb begin
    pc_d       = pc_load ? next_pc : pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (redir && !resp_a) begin
      // With a redirect active, next_pc is exactly the redirect target.
      pend_d     = 1'b1;
      pend_tgt_d = next_pc;
    end else if (resp_a) begin
      pend_d     = 1'b0;
      pend_tgt_d = 16'h0000;
    end
    ir_d = ir_q;
    if (flush)                           ir_d = 16'h0000;
    else if (pc_load && resp_a && !stall) ir_d = rdata_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      pend_q     <= 1'b0;
      pend_tgt_q <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_out      = pc_q;
  assign address_a   = pc_q;
  assign read_a      = 1'b1;
  assign instruction = ir_q;
  assign dest        = ir_q[11:9];
  assign src1        = ir_q[8:6];
  assign src2        = ir_q[2:0];

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Self-checking bench for lc3b_fetch_unit: expected PC/IR pairs are queued when
// stimulus is applied and compared one cycle later when the DUT has updated.
module tb_lc3b_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic [15:0] trap_mem;
  logic        br_en;
  logic        trap_en;
  logic        jmp_jsr_en;
  logic        b11;
  logic [15:0] pc_br_in;
  logic [15:0] sr1_data_in;
  logic [2:0]  pcmux_sel;
  logic        stall;
  logic        flush;
  logic [15:0] pc_out;
  logic [15:0] instruction;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic        read_a;
  logic [15:0] address_a;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pc_q[$];
  logic [15:0] exp_ir_q[$];

  lc3b_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .resp_a(resp_a), .rdata_a(rdata_a),
    .trap_mem(trap_mem), .br_en(br_en), .trap_en(trap_en),
    .jmp_jsr_en(jmp_jsr_en), .b11(b11), .pc_br_in(pc_br_in),
    .sr1_data_in(sr1_data_in), .pcmux_sel(pcmux_sel), .stall(stall),
    .flush(flush), .pc_out(pc_out), .instruction(instruction),
    .dest(dest), .src1(src1), .src2(src2), .read_a(read_a),
    .address_a(address_a)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    resp_a = 1'b0; rdata_a = 16'h0000; trap_mem = 16'h0000;
    br_en = 1'b0; trap_en = 1'b0; jmp_jsr_en = 1'b0; b11 = 1'b0;
    pc_br_in = 16'h0000; sr1_data_in = 16'h0000; pcmux_sel = 3'd0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc_out); end
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", instruction); end
    checks++; if ({dest, src1, src2} !== 9'd0) begin errors++; $display("FAIL reset_fields: got %b want 0", {dest, src1, src2}); end
    checks++; if (read_a !== 1'b1) begin errors++; $display("FAIL reset_read_a: got %b want 1", read_a); end
    checks++; if (address_a !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", address_a); end
    rst_n = 1'b1;
    exp_pc_q.push_back(16'h0000); exp_ir_q.push_back(16'h0000);
    tick();
    begin
      logic [15:0] p, i;
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL reset_idle_pc: got %h want %h", pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL reset_idle_ir: got %h want %h", instruction, i); end
    end
  endtask

  task automatic test_seq();
    logic [15:0] words [3];
    logic [15:0] p, i;
    words[0] = 16'h1234; words[1] = 16'h5A5A; words[2] = 16'h0E3F;
    for (int k = 0; k < 3; k++) begin
      idle(); resp_a = 1'b1; rdata_a = words[k];
      exp_pc_q.push_back(16'(2 * (k + 1))); exp_ir_q.push_back(words[k]);
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL seq_ir[%0d]: got %h want %h", k, instruction, i); end
      checks++; if (address_a !== p) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", k, address_a, p); end
      if (k == 0) begin
        checks++; if ({dest, src1, src2} !== {3'd1, 3'd0, 3'd4}) begin
          errors++; $display("FAIL seq_fields: got %0d/%0d/%0d want 1/0/4", dest, src1, src2); end
      end
      if (k == 2) begin
        checks++; if ({dest, src1, src2} !== {3'd7, 3'd0, 3'd7}) begin
          errors++; $display("FAIL seq_fields2: got %0d/%0d/%0d want 7/0/7", dest, src1, src2); end
      end
    end
  endtask

  task automatic test_branch_stall();
    logic [15:0] p, i;
    idle(); br_en = 1'b1; resp_a = 1'b1; pc_br_in = 16'h3000; stall = 1'b1; rdata_a = 16'hFFFF;
    exp_pc_q.push_back(16'h3000); exp_ir_q.push_back(16'h0E3F);
    tick();
    p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
    checks++; if (pc_out !== p) begin errors++; $display("FAIL br_stall_pc: got %h want %h", pc_out, p); end
    checks++; if (instruction !== i) begin errors++; $display("FAIL br_stall_ir: got %h want %h", instruction, i); end
  endtask

  task automatic test_trap_pending();
    logic [15:0] p, i;
    // {trap_en, resp_a, rdata, expected pc, expected ir}
    logic [49:0] tbl [4];
    tbl[0] = {1'b1, 1'b0, 16'h9999, 16'h3000, 16'h0E3F};
    tbl[1] = {1'b0, 1'b0, 16'h9999, 16'h0400, 16'h0E3F};
    tbl[2] = {1'b0, 1'b1, 16'h1111, 16'h0400, 16'h1111};
    tbl[3] = {1'b0, 1'b0, 16'h9999, 16'h0400, 16'h1111};
    for (int k = 0; k < 4; k++) begin
      idle(); trap_mem = 16'h0400;
      trap_en = tbl[k][49]; resp_a = tbl[k][48]; rdata_a = tbl[k][47:32];
      exp_pc_q.push_back(tbl[k][31:16]); exp_ir_q.push_back(tbl[k][15:0]);
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL trap_pend_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL trap_pend_ir[%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_jmp();
    logic [15:0] p, i;
    for (int k = 0; k < 2; k++) begin
      idle(); jmp_jsr_en = 1'b1; resp_a = 1'b1; b11 = k[0];
      sr1_data_in = 16'h5000; pc_br_in = 16'h6000; rdata_a = (k == 0) ? 16'h2222 : 16'h3333;
      exp_pc_q.push_back((k == 0) ? 16'h5000 : 16'h6000);
      exp_ir_q.push_back((k == 0) ? 16'h2222 : 16'h3333);
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL jmp_pc[b11=%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL jmp_ir[b11=%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_priority();
    logic [15:0] p, i;
    for (int k = 0; k < 3; k++) begin
      idle(); resp_a = 1'b1; pc_br_in = 16'h7000; trap_mem = 16'h0400; sr1_data_in = 16'h5000;
      rdata_a = 16'h4440 + 16'(k);
      case (k)
        0: begin br_en = 1'b1; trap_en = 1'b1; jmp_jsr_en = 1'b1; exp_pc_q.push_back(16'h7000); end
        1: begin trap_en = 1'b1; jmp_jsr_en = 1'b1; exp_pc_q.push_back(16'h0400); end
        default: begin jmp_jsr_en = 1'b1; pcmux_sel = 3'd3; exp_pc_q.push_back(16'h5000); end
      endcase
      exp_ir_q.push_back(16'h4440 + 16'(k));
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL prio_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL prio_ir[%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_redirect_pending();
    logic [15:0] p, i;
    for (int k = 0; k < 5; k++) begin
      idle(); trap_mem = 16'h0800; pc_br_in = 16'h7000; rdata_a = 16'h5555;
      case (k)
        0: begin trap_en = 1'b1; exp_pc_q.push_back(16'h5000); exp_ir_q.push_back(16'h4442); end
        1: begin br_en = 1'b1;   exp_pc_q.push_back(16'h7000); exp_ir_q.push_back(16'h4442); end
        2: begin                 exp_pc_q.push_back(16'h7000); exp_ir_q.push_back(16'h4442); end
        3: begin resp_a = 1'b1;  exp_pc_q.push_back(16'h7000); exp_ir_q.push_back(16'h5555); end
        default: begin           exp_pc_q.push_back(16'h7000); exp_ir_q.push_back(16'h5555); end
      endcase
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL redir_pend_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL redir_pend_ir[%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_flush_stall();
    logic [15:0] p, i;
    for (int k = 0; k < 4; k++) begin
      idle(); resp_a = 1'b1;
      case (k)
        0: begin flush = 1'b1; rdata_a = 16'hABCD; exp_pc_q.push_back(16'h7002); exp_ir_q.push_back(16'h0000); end
        1: begin rdata_a = 16'h6666; exp_pc_q.push_back(16'h7004); exp_ir_q.push_back(16'h6666); end
        2: begin stall = 1'b1; rdata_a = 16'h7777; exp_pc_q.push_back(16'h7004); exp_ir_q.push_back(16'h6666); end
        default: begin stall = 1'b1; flush = 1'b1; rdata_a = 16'h7777;
                       exp_pc_q.push_back(16'h7004); exp_ir_q.push_back(16'h0000); end
      endcase
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL flush_stall_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL flush_stall_ir[%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_mux_wrap();
    logic [15:0] p, i;
    // {sel, expected pc}; sources are fixed constants below
    logic [18:0] tbl [8];
    tbl[0] = {3'd3, 16'hFFFE};
    tbl[1] = {3'd0, 16'h0000};
    tbl[2] = {3'd2, 16'h1230};
    tbl[3] = {3'd4, 16'h0C00};
    tbl[4] = {3'd6, 16'h0000};
    tbl[5] = {3'd1, 16'h2468};
    tbl[6] = {3'd7, 16'h0000};
    tbl[7] = {3'd5, 16'h0000};
    for (int k = 0; k < 8; k++) begin
      idle(); resp_a = 1'b1; pcmux_sel = tbl[k][18:16];
      sr1_data_in = 16'h1230; trap_mem = 16'h0C00; pc_br_in = 16'h2468;
      rdata_a = (k == 0) ? 16'hFFFE : 16'h0100 + 16'(k);
      exp_pc_q.push_back(tbl[k][15:0]);
      exp_ir_q.push_back((k == 0) ? 16'hFFFE : 16'h0100 + 16'(k));
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL mux_pc[sel=%0d]: got %h want %h", tbl[k][18:16], pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL mux_ir[sel=%0d]: got %h want %h", tbl[k][18:16], instruction, i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p, i, mpc, mir;
    mpc = pc_out; mir = instruction;
    for (int k = 0; k < 24; k++) begin
      idle();
      resp_a  = 1'($urandom_range(0, 3) != 0);
      stall   = 1'($urandom_range(0, 3) == 0);
      rdata_a = 16'($urandom);
      if (resp_a && !stall) begin mpc = mpc + 16'd2; mir = rdata_a; end
      exp_pc_q.push_back(mpc); exp_ir_q.push_back(mir);
      tick();
      p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
      checks++; if (pc_out !== p) begin errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, pc_out, p); end
      checks++; if (instruction !== i) begin errors++; $display("FAIL b2b_ir[%0d]: got %h want %h", k, instruction, i); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] p, i;
    idle(); resp_a = 1'b1; rdata_a = 16'hBEEF;
    tick();
    idle(); trap_en = 1'b1; trap_mem = 16'h0400;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL midrst_pc: got %h want 0000", pc_out); end
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL midrst_ir: got %h want 0000", instruction); end
    tick();
    rst_n = 1'b1;
    // A stale pending flag would let this unanswered redirect move the PC.
    idle(); br_en = 1'b1; pc_br_in = 16'h1111;
    exp_pc_q.push_back(16'h0000); exp_ir_q.push_back(16'h0000);
    tick();
    p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
    checks++; if (pc_out !== p) begin errors++; $display("FAIL midrst_pend_pc: got %h want %h", pc_out, p); end
    checks++; if (instruction !== i) begin errors++; $display("FAIL midrst_pend_ir: got %h want %h", instruction, i); end
    idle(); resp_a = 1'b1; rdata_a = 16'h2020;
    exp_pc_q.push_back(16'h1111); exp_ir_q.push_back(16'h2020);
    tick();
    p = exp_pc_q.pop_front(); i = exp_ir_q.pop_front();
    checks++; if (pc_out !== p) begin errors++; $display("FAIL midrst_drain_pc: got %h want %h", pc_out, p); end
    checks++; if (instruction !== i) begin errors++; $display("FAIL midrst_drain_ir: got %h want %h", instruction, i); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch_stall();
    test_trap_pending();
    test_jmp();
    test_priority();
    test_redirect_pending();
    test_flush_stall();
    test_mux_wrap();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
